// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, ALU operation codes and the ID/EX control bundle for decode_ctrl_stage.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [4:0] {
    ALU_ADD       = 5'd0,
    ALU_SUB       = 5'd1,
    ALU_AND       = 5'd2,
    ALU_OR        = 5'd3,
    ALU_XOR       = 5'd4,
    ALU_SLT       = 5'd5,
    ALU_SLTU      = 5'd6,
    ALU_SLL       = 5'd7,
    ALU_SRL       = 5'd8,
    ALU_SRA       = 5'd9,
    ALU_COPY_SRC2 = 5'd11,
    ALU_MUL       = 5'd16,
    ALU_MULH      = 5'd17,
    ALU_MULHSU    = 5'd18,
    ALU_MULHU     = 5'd19,
    ALU_DIV       = 5'd20,
    ALU_DIVU      = 5'd21,
    ALU_REM       = 5'd22,
    ALU_REMU      = 5'd23
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic       illegal;
  } stage_t;

  localparam ctrl_t  CTRL_BUBBLE  = ctrl_t'('0);
  localparam stage_t STAGE_BUBBLE = stage_t'('0);

  // alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I instruction decoder; RV32M R-type ops are enabled by `RV32M_EN.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct3 = instr[14:12];

  assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2 = opcode inside {OPC_R, OPC_STORE, OPC_BRANCH};

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = alu_from_funct3(funct3, funct7[5]);
        end
`ifdef RV32M_EN
        else if (funct7 == 7'b0000001) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = alu_op_e'(5'd16 + {2'b00, funct3});
        end
`endif
        else begin
          illegal = 1'b1;
        end
      end
      OPC_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = alu_from_funct3(funct3, funct3 == 3'b101 && instr[30]);
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_COPY_SRC2;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.jump      = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered ID/EX decode stage with load-use stall, flush and a saturating bubble counter.
// Build option: define RV32M_EN to decode RV32M multiply/divide instructions.
module decode_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_WIDTH = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [31:0]             instr,
  output logic                    in_ready_o,
  input  logic                    flush,
  input  logic                    ex_ready,
  output logic                    out_valid_o,
  output logic                    RegWrite_o,
  output logic                    MemToReg_o,
  output logic                    MemRead_o,
  output logic                    MemWrite_o,
  output logic                    Branch_o,
  output logic                    ALUSrc_o,
  output logic                    Jump_o,
  output logic [ALU_OP_WIDTH-1:0] ALUOp_o,
  output logic [4:0]              rd_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [2:0]              funct3_o,
  output logic                    illegal_o,
  output logic [CNT_W-1:0]        bubble_cnt_o
);

  stage_t           st;
  stage_t           dec;
  ctrl_t            dec_ctrl;
  logic [4:0]       dec_rd;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [2:0]       dec_funct3;
  logic             dec_uses_rs1;
  logic             dec_uses_rs2;
  logic             dec_illegal;
  logic             hazard;
  logic             accept;
  logic [CNT_W-1:0] cnt;

  instr_decoder u_dec (
    .instr    (instr),
    .ctrl     (dec_ctrl),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .funct3   (dec_funct3),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  assign dec = '{valid: 1'b1, ctrl: dec_ctrl, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                 funct3: dec_funct3, illegal: dec_illegal};

  // Only a held load with a non-zero destination can stall the incoming instruction.
  assign hazard = st.valid && st.ctrl.mem_read && in_valid && (st.rd != 5'd0) &&
                  ((dec_uses_rs1 && dec_rs1 == st.rd) || (dec_uses_rs2 && dec_rs2 == st.rd));

  assign in_ready_o = !flush && !hazard && (!st.valid || ex_ready);
  assign accept     = in_valid && in_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= STAGE_BUBBLE;
      cnt <= '0;
    end else if (flush) begin
      st <= STAGE_BUBBLE;
    end else if (accept) begin
      st <= dec;
    end else if (hazard && ex_ready) begin
      st <= STAGE_BUBBLE;
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else if (st.valid && ex_ready) begin
      st <= STAGE_BUBBLE;
    end
  end

  assign out_valid_o  = st.valid;
  assign RegWrite_o   = st.ctrl.reg_write;
  assign MemToReg_o   = st.ctrl.mem_to_reg;
  assign MemRead_o    = st.ctrl.mem_read;
  assign MemWrite_o   = st.ctrl.mem_write;
  assign Branch_o     = st.ctrl.branch;
  assign ALUSrc_o     = st.ctrl.alu_src;
  assign Jump_o       = st.ctrl.jump;
  assign ALUOp_o      = ALU_OP_WIDTH'(st.ctrl.alu_op);
  assign rd_o         = st.rd;
  assign rs1_o        = st.rs1;
  assign rs2_o        = st.rs2;
  assign funct3_o     = st.funct3;
  assign illegal_o    = st.illegal;
  assign bubble_cnt_o = cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Randomized self-checking bench for decode_ctrl_stage against a behavioural stage model.
module tb_decode_ctrl_stage;

  localparam int CW = 4;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   instr;
  logic          in_ready_o;
  logic          flush;
  logic          ex_ready;
  logic          out_valid_o;
  logic          RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o, Jump_o;
  logic [4:0]    ALUOp_o;
  logic [4:0]    rd_o, rs1_o, rs2_o;
  logic [2:0]    funct3_o;
  logic          illegal_o;
  logic [CW-1:0] bubble_cnt_o;

  decode_ctrl_stage #(.ALU_OP_WIDTH(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready_o(in_ready_o),
    .flush(flush), .ex_ready(ex_ready), .out_valid_o(out_valid_o),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .Branch_o(Branch_o), .ALUSrc_o(ALUSrc_o), .Jump_o(Jump_o),
    .ALUOp_o(ALUOp_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
    .illegal_o(illegal_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, rw, mtr, mr, mw, br, as, jp;
    logic [4:0] op, rd, rs1, rs2;
    logic [2:0] f3;
    logic       ill;
  } exp_t;

  int   n_vec  = 0;
  int   n_err  = 0;
  exp_t m;
  int   m_cnt;
  logic m_rdy;
  int   aluf3 [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    e = bubble();
    e.v = 1'b1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
    case (opc)
      7'h33: begin
        if (f7 == 7'h00) begin e.rw = 1; e.op = 5'(aluf3[f3]); end
        else if (f7 == 7'h20 && f3 == 3'd0) begin e.rw = 1; e.op = 5'd1; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin e.rw = 1; e.op = 5'd9; end
        else if (M_EN && f7 == 7'h01) begin e.rw = 1; e.op = 5'(16 + int'(f3)); end
        else e.ill = 1;
      end
      7'h13: begin e.rw = 1; e.as = 1; e.op = (f3 == 3'd5 && w[30]) ? 5'd9 : 5'(aluf3[f3]); end
      7'h03: begin e.rw = 1; e.mtr = 1; e.mr = 1; e.as = 1; end
      7'h23: begin e.mw = 1; e.as = 1; end
      7'h63: begin e.br = 1; e.op = 5'd1; end
      7'h37: begin e.rw = 1; e.as = 1; e.op = 5'd11; end
      7'h17: begin e.rw = 1; e.as = 1; end
      7'h6f: begin e.rw = 1; e.jp = 1; end
      7'h67: begin e.rw = 1; e.as = 1; e.jp = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic ref_hazard(input logic iv, input logic [31:0] w);
    logic u1, u2;
    u1 = !(w[6:0] inside {7'h37, 7'h17, 7'h6f});
    u2 = w[6:0] inside {7'h33, 7'h23, 7'h63};
    return m.v && m.mr && iv && m.rd != 0 &&
           ((u1 && w[19:15] == m.rd) || (u2 && w[24:20] == m.rd));
  endfunction

  task automatic compare_all();
    check("out_valid", out_valid_o, m.v);
    check("RegWrite", RegWrite_o, m.rw);
    check("MemToReg", MemToReg_o, m.mtr);
    check("MemRead", MemRead_o, m.mr);
    check("MemWrite", MemWrite_o, m.mw);
    check("Branch", Branch_o, m.br);
    check("ALUSrc", ALUSrc_o, m.as);
    check("Jump", Jump_o, m.jp);
    check("ALUOp", ALUOp_o, m.op);
    check("rd", rd_o, m.rd);
    check("rs1", rs1_o, m.rs1);
    check("rs2", rs2_o, m.rs2);
    check("funct3", funct3_o, m.f3);
    check("illegal", illegal_o, m.ill);
    check("bubble_cnt", bubble_cnt_o, m_cnt);
  endtask

  // One clock: drive at negedge, check the ready decision, then check the registered result.
  task automatic step(input logic iv, input logic [31:0] w, input logic fl, input logic er);
    logic hz;
    @(negedge clk);
    in_valid = iv; instr = w; flush = fl; ex_ready = er;
    hz    = ref_hazard(iv, w);
    m_rdy = !fl && !hz && (!m.v || er);
    #1 check("in_ready", in_ready_o, m_rdy);
    @(posedge clk);
    if (fl) m = bubble();
    else if (iv && m_rdy) m = ref_decode(w);
    else if (hz && er) begin
      m = bubble();
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (m.v && er) m = bubble();
    #1 compare_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    m = bubble(); m_cnt = 0;
    #1 compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] rnd;
    logic [6:0]  f7, opc;
    logic [4:0]  rd, rs1, rs2;
    rnd = $urandom;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2:    f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h01;
      default: f7 = rnd[31:25];
    endcase
    case ($urandom_range(0, 11))
      0, 1: opc = 7'h33;
      2:    opc = 7'h13;
      3, 4: opc = 7'h03;
      5:    opc = 7'h23;
      6:    opc = 7'h63;
      7:    opc = 7'h37;
      8:    opc = 7'h17;
      9:    opc = 7'h6f;
      10:   opc = 7'h67;
      default: return rnd;
    endcase
    return {f7, rs2, rs1, rnd[14:12], rd, opc};
  endfunction

  localparam logic [31:0] ADD_X3  = 32'h002081B3;
  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_X6  = 32'h00228333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X0S = 32'h00200333;
  localparam logic [31:0] SW_X2   = 32'h0020A023;
  localparam logic [31:0] BEQ     = 32'h00208063;
  localparam logic [31:0] MUL_X1  = 32'h023100B3;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; ex_ready = 1'b0;
    m = bubble(); m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst = 1'b0;

    step(1, ADD_X3, 0, 1);
    check("add_regwrite", RegWrite_o, 1);
    check("add_rd", rd_o, 3);

    step(1, LW_X5, 0, 1);
    step(1, ADD_X6, 0, 1);
    check("lu_stall_valid", out_valid_o, 0);
    check("lu_cnt", bubble_cnt_o, 1);
    step(1, ADD_X6, 0, 1);
    check("lu_issue_rd", rd_o, 6);

    step(1, LW_X0, 0, 1);
    step(1, ADD_X0S, 0, 1);
    check("x0_no_stall", out_valid_o, 1);

    step(1, SW_X2, 0, 1);
    repeat (3) step(1, ADD_X3, 0, 0);
    check("sw_held", MemWrite_o, 1);
    step(1, ADD_X3, 0, 1);

    step(1, BEQ, 0, 1);
    step(1, ADD_X3, 1, 1);
    check("flush_valid", out_valid_o, 0);

    step(1, MUL_X1, 0, 1);
    check("mul_illegal", illegal_o, !M_EN);
    step(0, '0, 0, 1);

    repeat (20) begin
      step(1, LW_X5, 0, 1);
      step(1, ADD_X6, 0, 1);
      step(1, ADD_X6, 0, 1);
    end
    check("cnt_saturated", bubble_cnt_o, (1 << CW) - 1);

    async_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step($urandom_range(0, 3) != 0, rand_instr(),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
